uart_rx_os: RTL and testbench

Parametrised next-generation UART receiver: oversampled start/data detection with 3-sample majority vote, 5–8 data bits, and four parity modes. Reports framing error, break, overrun and character timeout (CTI). It sits between the synchronised uart_rx_i pin and the 9+ bit RX FIFO of the APB4 UART. Its timeout output drives the CTI input of uart_irq, which is currently tied to 0.

---
 rtl/uart_pkg.sv | 50 +++++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_rx_os.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and encodings.
// Used by the oversampled receiver and the baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_e;

    localparam logic [1:0] PAR_EVEN   = 2'b00;
    localparam logic [1:0] PAR_ODD    = 2'b01;
    localparam logic [1:0] PAR_STICK0 = 2'b10;
    localparam logic [1:0] PAR_STICK1 = 2'b11;

    localparam logic [1:0] WLEN_5 = 2'b00;
    localparam logic [1:0] WLEN_6 = 2'b01;
    localparam logic [1:0] WLEN_7 = 2'b10;
    localparam logic [1:0] WLEN_8 = 2'b11;

    // Bits per frame: start + data + optional parity + stop(s).
    function automatic logic [3:0] frame_bits(
        input logic [1:0] bits,
        input logic       par_en,
        input logic       stop2
    );
        return 4'd7 + {2'b00, bits} + {3'b000, par_en} + {3'b000, stop2};
    endfunction

    function automatic logic par_err(
        input logic [1:0] sel,
        input logic       data_xor,
        input logic       bit_in
    );
        logic w_err;
        w_err = 1'b0;
        unique case (sel)
            PAR_EVEN:   w_err = data_xor ^ bit_in;
            PAR_ODD:    w_err = ~(data_xor ^ bit_in);
            PAR_STICK0: w_err = bit_in;
            PAR_STICK1: w_err = ~bit_in;
            default:    w_err = 1'b0;
        endcase
        return w_err;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Sample-tick prescaler with restart; divisors 0 and 1 act as 2.
// Shared between the receiver and a future oversampled transmitter.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_last;
    logic                 w_wrap;

    assign w_last = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(1) : div_i - 1'b1;
    assign w_wrap = (r_cnt >= w_last);
    assign tick_o = en_i & ~restart_i & w_wrap;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (!en_i || restart_i) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with majority voting, parity,
// framing/break/overrun detection and character timeout.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH     = 16,
    parameter int OVERSAMPLE    = 16,
    parameter int TIMEOUT_CHARS = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    input  logic                 cfg_en_i,
    input  logic [DIV_WIDTH-1:0] cfg_div_i,
    input  logic [1:0]           cfg_bits_i,
    input  logic                 cfg_parity_en_i,
    input  logic [1:0]           cfg_parity_sel_i,
    input  logic                 cfg_stop_bits_i,
    output logic [7:0]           rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 overrun_o,
    input  logic                 err_clr_i,
    output logic                 timeout_o,
    output logic                 busy_o
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam int TO_W = $clog2(TIMEOUT_CHARS * 12 + 1);
    localparam logic [OS_W-1:0] S0      = OS_W'(OVERSAMPLE / 2 - 2);
    localparam logic [OS_W-1:0] S1      = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] SV      = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;
    rx_state_e              r_state;
    logic [OS_W-1:0]        r_os;
    logic                   r_s0;
    logic                   r_s1;
    logic [2:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic                   r_zero;
    logic                   r_perr;
    logic [1:0]             r_bits;
    logic                   r_par_en;
    logic [1:0]             r_par_sel;
    logic                   r_stop2;

    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_perr_o;
    logic                   r_ferr;
    logic                   r_brk;
    logic                   r_ovr;
    logic                   r_timeout;
    logic                   r_armed;
    logic [TO_W-1:0]        r_to_cnt;

    logic                   w_rx;
    logic                   w_fall;
    logic                   w_start;
    logic                   w_tick;
    logic                   w_vote_now;
    logic                   w_vote;
    logic                   w_done;
    logic                   w_brk;
    logic                   w_hs;
    logic                   w_load;
    logic                   w_bit_end;
    logic [2:0]             w_last_bit;
    logic [TO_W-1:0]        w_limit;

    assign w_rx       = r_sync[SYNC_STAGES-1];
    assign w_fall     = r_rx_d & ~w_rx;
    assign w_start    = cfg_en_i & (r_state == IDLE) & w_fall;
    assign w_vote_now = w_tick & (r_os == SV);
    assign w_vote     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_done     = cfg_en_i & w_vote_now & (r_state == STOP);
    assign w_brk      = ~w_vote & r_zero;
    assign w_hs       = r_valid & rx_ready_i;
    assign w_load     = w_done & (~r_valid | rx_ready_i);
    assign w_bit_end  = w_tick & (r_os == OS_LAST) & (r_state == IDLE);
    assign w_last_bit = 3'(r_bits) + 3'd4;
    assign w_limit    = TO_W'(TIMEOUT_CHARS)
                      * TO_W'(frame_bits(r_bits, r_par_en, r_stop2));

    assign rx_data_o    = r_data;
    assign rx_valid_o   = r_valid;
    assign parity_err_o = r_perr_o;
    assign frame_err_o  = r_ferr;
    assign break_o      = r_brk;
    assign overrun_o    = r_ovr;
    assign timeout_o    = r_timeout;
    assign busy_o       = (r_state != IDLE);

    uart_baud_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_baud (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (cfg_en_i),
        .restart_i (w_start),
        .div_i     (cfg_div_i),
        .tick_o    (w_tick)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rx_d <= w_rx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_os      <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_zero    <= 1'b0;
            r_perr    <= 1'b0;
            r_bits    <= WLEN_8;
            r_par_en  <= 1'b0;
            r_par_sel <= PAR_EVEN;
            r_stop2   <= 1'b0;
        end else if (!cfg_en_i) begin
            r_state <= IDLE;
            r_os    <= '0;
        end else begin
            // Tick counter also free-runs in IDLE to time the character timeout.
            if (w_tick) begin
                r_os <= (r_os == OS_LAST) ? '0 : r_os + 1'b1;
                if (r_os == S0) r_s0 <= w_rx;
                if (r_os == S1) r_s1 <= w_rx;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state   <= START;
                        r_os      <= '0;
                        r_bitcnt  <= '0;
                        r_shift   <= '0;
                        r_par     <= 1'b0;
                        r_zero    <= 1'b1;
                        r_perr    <= 1'b0;
                        r_bits    <= cfg_bits_i;
                        r_par_en  <= cfg_parity_en_i;
                        r_par_sel <= cfg_parity_sel_i;
                        r_stop2   <= cfg_stop_bits_i;
                    end
                end
                START: begin
                    if (w_vote_now) r_state <= w_vote ? IDLE : DATA;
                end
                DATA: begin
                    if (w_vote_now) begin
                        r_shift[r_bitcnt] <= w_vote;
                        r_par             <= r_par ^ w_vote;
                        r_zero            <= r_zero & ~w_vote;
                        r_bitcnt          <= r_bitcnt + 1'b1;
                        if (r_bitcnt == w_last_bit)
                            r_state <= r_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (w_vote_now) begin
                        r_perr  <= par_err(r_par_sel, r_par, w_vote);
                        r_zero  <= r_zero & ~w_vote;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_vote_now) r_state <= w_brk ? BREAK_WAIT : IDLE;
                end
                BREAK_WAIT: begin
                    if (w_tick && w_rx) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr   <= 1'b0;
            r_brk    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            if (w_load) begin
                r_data   <= r_shift;
                r_valid  <= 1'b1;
                r_perr_o <= r_perr & ~w_brk;
                r_ferr   <= ~w_vote;
                r_brk    <= w_brk;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_done && r_valid && !rx_ready_i) begin
                r_ovr <= 1'b1;
            end else if (err_clr_i) begin
                r_ovr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_armed   <= 1'b0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!cfg_en_i) begin
                r_armed  <= 1'b0;
                r_to_cnt <= '0;
            end else if (w_done) begin
                r_armed  <= 1'b1;
                r_to_cnt <= '0;
            end else if (r_armed && w_bit_end) begin
                r_to_cnt <= r_to_cnt + 1'b1;
                if (r_to_cnt + 1'b1 == w_limit) begin
                    r_timeout <= 1'b1;
                    r_armed   <= 1'b0;
                end
            end
            if (w_start || w_hs) r_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: directed frames, monitor pops
// expected characters on every accepted handshake.
module tb_uart_rx_os;

    localparam int BIT = 64;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       br;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_bits;
    logic        cfg_par_en;
    logic [1:0]  cfg_par_sel;
    logic        cfg_stop;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        perr;
    logic        ferr;
    logic        brk;
    logic        ovr;
    logic        err_clr;
    logic        tmo;
    logic        busy;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t q[$];

    uart_rx_os dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .rx_i             (rx),
        .cfg_en_i         (cfg_en),
        .cfg_div_i        (cfg_div),
        .cfg_bits_i       (cfg_bits),
        .cfg_parity_en_i  (cfg_par_en),
        .cfg_parity_sel_i (cfg_par_sel),
        .cfg_stop_bits_i  (cfg_stop),
        .rx_data_o        (rx_data),
        .rx_valid_o       (rx_valid),
        .rx_ready_i       (rx_ready),
        .parity_err_o     (perr),
        .frame_err_o      (ferr),
        .break_o          (brk),
        .overrun_o        (ovr),
        .err_clr_i        (err_clr),
        .timeout_o        (tmo),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int val,
                             input int lo, input int hi);
        n_checks++;
        if (val < lo || val > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic pe,
                        input logic fe, input logic br);
        exp_t e;
        e.d  = d;
        e.pe = pe;
        e.fe = fe;
        e.br = br;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_char: got data %0h, expected none",
                         rx_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_data", rx_data, e.d);
                check("sb_parity_err", perr, e.pe);
                check("sb_frame_err", ferr, e.fe);
                check("sb_break", brk, e.br);
            end
        end
    end

    task automatic hold(input logic v, input int clks);
        rx = v;
        repeat (clks) @(posedge clk);
    endtask

    // glitch_bit >= 0 puts a 4-clk low pulse at the centre of that data bit.
    task automatic send(input logic [7:0] d, input int nb, input bit pen,
                        input logic pbit, input logic stop_v,
                        input int glitch_bit);
        hold(1'b0, BIT);
        for (int i = 0; i < nb; i++) begin
            if (i == glitch_bit) begin
                hold(1'b1, 30);
                hold(1'b0, 4);
                hold(1'b1, 30);
            end else begin
                hold(d[i], BIT);
            end
        end
        if (pen) hold(pbit, BIT);
        hold(stop_v, BIT);
        rx = 1'b1;
    endtask

    task automatic idle(input int nbits);
        hold(1'b1, nbits * BIT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        rx          = 1'b1;
        cfg_en      = 1'b1;
        cfg_div     = 16'd4;
        cfg_bits    = 2'b11;
        cfg_par_en  = 1'b0;
        cfg_par_sel = 2'b00;
        cfg_stop    = 1'b0;
        rx_ready    = 1'b1;
        err_clr     = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_overrun", ovr, 0);
        check("rst_timeout", tmo, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(2);

        // 8N1 0xA5 with latency measurement
        push(8'hA5, 0, 0, 0);
        fork
            send(8'hA5, 8, 0, 0, 1, -1);
            begin
                n = 0;
                while (!rx_valid && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check_rng("a5_latency", n, 576, 640);
            end
        join
        idle(2);

        // 7E1 0x3C, inverted parity bit: correct even bit is 0
        cfg_bits   = 2'b10;
        cfg_par_en = 1'b1;
        push(8'h3C, 1, 0, 0);
        send(8'h3C, 7, 1, 1'b1, 1, -1);
        idle(2);
        // stick-1 with parity bit 1
        cfg_par_sel = 2'b11;
        push(8'h3C, 0, 0, 0);
        send(8'h3C, 7, 1, 1'b1, 1, -1);
        idle(2);
        // 8O1 0x5A (four ones, odd bit 1) is clean
        cfg_bits    = 2'b11;
        cfg_par_sel = 2'b01;
        push(8'h5A, 0, 0, 0);
        send(8'h5A, 8, 1, 1'b1, 1, -1);
        idle(2);
        cfg_par_en = 1'b0;

        // short low glitch on idle line is a false start
        hold(1'b0, 12);
        idle(2);
        @(negedge clk);
        check("glitch_busy", busy, 0);
        check("glitch_valid", rx_valid, 0);

        // single-sample glitch at a data-bit centre is voted out
        push(8'hFF, 0, 0, 0);
        send(8'hFF, 8, 0, 0, 1, 3);
        idle(2);

        // framing error
        push(8'h55, 0, 1, 0);
        send(8'h55, 8, 0, 0, 0, -1);
        idle(2);

        // break: line low for 20 bit times
        push(8'h00, 0, 1, 1);
        hold(1'b0, 20 * BIT);
        @(negedge clk);
        check("break_wait_busy", busy, 1);
        idle(2);
        @(negedge clk);
        check("break_end_busy", busy, 0);

        // overrun
        rx_ready = 1'b0;
        push(8'h11, 0, 0, 0);
        send(8'h11, 8, 0, 0, 1, -1);
        send(8'h22, 8, 0, 0, 1, -1);
        @(negedge clk);
        check("ovr_valid", rx_valid, 1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_flag", ovr, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("ovr_clear", ovr, 0);
        rx_ready = 1'b1;
        idle(2);

        // character timeout
        push(8'h3A, 0, 0, 0);
        fork
            send(8'h3A, 8, 0, 0, 1, -1);
            begin
                n = 0;
                while (!rx_valid && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check("tmo_before", tmo, 0);
                n = 0;
                while (!tmo && n < 4000) begin
                    @(negedge clk);
                    n++;
                end
                check_rng("tmo_delay", n, 2496, 2624);
            end
        join
        while (!tmo && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("tmo_level", tmo, 1);
        push(8'h42, 0, 0, 0);
        fork
            send(8'h42, 8, 0, 0, 1, -1);
            begin
                repeat (BIT) @(negedge clk);
                check("tmo_cleared", tmo, 0);
            end
        join
        idle(2);

        // reset mid-DATA
        fork
            send(8'h77, 8, 0, 0, 1, -1);
            begin
                repeat (3 * BIT) @(negedge clk);
                check("pre_rst_busy", busy, 1);
                rst_n = 1'b0;
                #1;
                check("mid_rst_busy", busy, 0);
                check("mid_rst_valid", rx_valid, 0);
                check("mid_rst_data", rx_data, 0);
                check("mid_rst_flags", {perr, ferr, brk, ovr, tmo}, 0);
            end
        join
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        @(negedge clk);
        check("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
